// File: rtl/x7seg_pkg.sv
// x7seg_pkg -- shared definitions for the binary-to-BCD converter and the
// 4-digit multiplexed 7-segment display driver.
//   state_t    : converter FSM state encoding (IDLE, SHIFT, DONE)
//   BCD_W      : bits per BCD digit
//   NUM_DIGITS : digits on the display / in the BCD accumulator
//   MAX_DEC    : largest value representable in NUM_DIGITS decimal digits
//   SAT_VALUE  : display value used when a conversion saturates
package x7seg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned BCD_W      = 4;
   localparam int unsigned NUM_DIGITS = 4;
   localparam logic [13:0] MAX_DEC    = 14'd9999;
   localparam logic [15:0] SAT_VALUE  = 16'h9999;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3 -- per-digit correction step of the shift-add-3 algorithm.
// A digit of 5 or more is biased by 3 so that the following left shift
// carries correctly into the next decimal digit.
// Ports:
//   d : BCD digit before correction
//   q : corrected digit, (d >= 5) ? d + 3 : d
module bcd_add3
   import x7seg_pkg::*;
(
   input  logic [BCD_W-1:0] d,
   output logic [BCD_W-1:0] q
);

   always_comb begin
      q = d;
      if (d >= BCD_W'(5))
         q = d + BCD_W'(3);
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential binary-to-BCD converter, one bit per clock.
// Produces the 16-bit x bus for the 4-digit 7-segment driver.
// Ports:
//   clk   : clock
//   clr   : asynchronous active-high reset
//   start : conversion request, accepted only in IDLE
//   bin   : binary value, sampled on the edge that accepts start
//   busy  : high while in SHIFT or DONE
//   done  : one-cycle pulse; bcd/ovf take their new values in this cycle
//   ovf   : input exceeded 9999 (held with bcd)
//   bcd   : {d3,d2,d1,d0}, d0 in [3:0]
// Build option:
//   BIN2BCD_SAT_EN : when defined, an overflowing input displays 16'h9999;
//                    otherwise the display shows bin mod 10000.
module bin2bcd_seq
   import x7seg_pkg::*;
#(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [15:0]      bcd
);

   localparam int unsigned ACC_W = BCD_W * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W);

   if (BIN_W < 4 || BIN_W > 14) begin : g_bad_bin_w
      $error("bin2bcd_seq: BIN_W must be in 4..14");
   end
   if (DIGITS != NUM_DIGITS) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS must be 4");
   end

   state_t state, state_next;

   logic [ACC_W-1:0]       bcd_acc;
   logic [ACC_W-1:0]       bcd_corr;
   logic [BIN_W-1:0]       bin_acc;
   logic [CNT_W-1:0]       cnt;
   logic                   ovf_n;
   logic                   last;
   logic [ACC_W+BIN_W-1:0] shifted;
   logic [ACC_W-1:0]       result;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_add3 u_add3 (
         .d (bcd_acc[i*BCD_W +: BCD_W]),
         .q (bcd_corr[i*BCD_W +: BCD_W])
      );
   end

   // The bit shifted out of d3 is dropped, which leaves bin mod 10000.
   assign shifted = {bcd_corr, bin_acc} << 1;
   assign last    = (cnt == CNT_W'(BIN_W - 1));

`ifdef BIN2BCD_SAT_EN
   assign result = ovf_n ? SAT_VALUE : shifted[BIN_W +: ACC_W];
`else
   assign result = shifted[BIN_W +: ACC_W];
`endif

   // State register
   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state; DONE lasts exactly one cycle, so done
   // is the one-cycle pulse that coincides with the new bcd/ovf values.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         SHIFT:   busy = 1'b1;
         DONE:    begin busy = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         bcd_acc <= '0;
         bin_acc <= '0;
         cnt     <= '0;
         ovf_n   <= 1'b0;
         bcd     <= '0;
         ovf     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  bcd_acc <= '0;
                  bin_acc <= bin;
                  cnt     <= '0;
                  ovf_n   <= (32'(bin) > 32'(MAX_DEC));
               end
            end
            SHIFT: begin
               {bcd_acc, bin_acc} <= shifted;
               cnt                <= cnt + CNT_W'(1);
               if (last) begin
                  bcd <= result;
                  ovf <= ovf_n;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq -- directed self-checking bench for bin2bcd_seq (BIN_W=14).
// Expected BCD values are hand-written for the directed cases and come
// from a small decimal model for the sweep. Honours BIN2BCD_SAT_EN.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        start = 1'b0;
   logic [13:0] bin = '0;
   logic        busy, done, ovf;
   logic [15:0] bcd;

   int checks   = 0;
   int failures = 0;

   bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
      .clk   (clk),
      .clr   (clr),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf),
      .bcd   (bcd)
   );

   always #5 clk = ~clk;

`ifdef BIN2BCD_SAT_EN
   localparam logic [15:0] EXP_10000 = 16'h9999;
   localparam logic [15:0] EXP_16383 = 16'h9999;
`else
   localparam logic [15:0] EXP_10000 = 16'h0000;
   localparam logic [15:0] EXP_16383 = 16'h6383;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs and samples happen 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      int r;
      r = v % 10000;
      return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
   endfunction

   task automatic do_conv(input int v, input logic [15:0] exp_bcd, input logic exp_ovf,
                          input string tag);
      int n;
      start = 1'b1;
      bin   = v[13:0];
      tick();
      start = 1'b0;
      bin   = 14'($urandom);
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, n, 14);
      check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
      check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
      tick();
      check({tag, "_done_width"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #100_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int ndone, d1, d2;
      logic [15:0] b1, b2;

      // Reset state
      repeat (3) tick();
      clr = 1'b0;
      tick();
      check("rst_bcd",  32'(bcd),  32'h0);
      check("rst_ovf",  32'(ovf),  32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);

      do_conv(0, 16'h0000, 1'b0, "zero");
      do_conv(1234, 16'h1234, 1'b0, "v1234");

      // Result holds through idle cycles
      bad = 0;
      repeat (20) begin
         tick();
         if (bcd !== 16'h1234 || done !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("hold_1234", bad, 0);

      do_conv(9999,  16'h9999, 1'b0, "v9999");
      do_conv(10000, EXP_10000, 1'b1, "v10000");
      do_conv(16383, EXP_16383, 1'b1, "v16383");

      // start held high; bin changes after the accept edge
      start = 1'b1;
      bin   = 14'd4321;
      tick();
      bin   = 14'd42;
      ndone = 0; d1 = -1; d2 = -1; b1 = '0; b2 = '0;
      for (int i = 1; i <= 31; i++) begin
         tick();
         if (done) begin
            ndone++;
            if (ndone == 1) begin d1 = i; b1 = bcd; end
            else if (ndone == 2) begin d2 = i; b2 = bcd; end
         end
      end
      start = 1'b0;
      check("storm_ndone",   ndone, 2);
      check("storm_first_t", d1, 14);
      check("storm_first",   32'(b1), 32'h4321);
      check("storm_spacing", d2 - d1, 16);
      check("storm_second",  32'(b2), 32'h0042);
      tick();
      check("storm_idle", 32'(busy), 32'd0);

      // Reset in the middle of a conversion
      do_conv(321, 16'h0321, 1'b0, "v321");
      start = 1'b1;
      bin   = 14'd5678;
      tick();
      start = 1'b0;
      repeat (6) tick();
      clr = 1'b1;
      #1;
      check("abort_bcd",  32'(bcd),  32'h0);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      bad = 0;
      repeat (20) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      clr = 1'b0;
      repeat (16) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0 || bcd !== 16'h0000) bad++;
      end
      check("abort_no_done", bad, 0);
      do_conv(77, 16'h0077, 1'b0, "v77");

      // Sweep against the decimal model
      for (int v = 0; v <= 9999; v += 37)
         do_conv(v, to_bcd(v), 1'b0, "sweep");
      do_conv(9998, to_bcd(9998), 1'b0, "sweep_hi");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter (shift-add-3, one bit per clock) that sits directly upstream of the 4-digit multiplexed 7-segment driver. It produces the 16-bit x bus that the driver consumes: four BCD nibbles, with digit 0 in bits [3:0]. The start/busy/done handshake lets a counter or controller request a conversion and latch a stable display value.

Parameters:
- BIN_W, 14, width of the binary input; legal range 4..14. Elaboration error outside this range.
- DIGITS, 4, number of BCD digits produced. Fixed at 4 in this revision; any other value is an elaboration error.

Ports:
- clk  input  1  clock.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  BIN_W  binary value; sampled on the same edge that accepts start.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; bcd and ovf are updated on this cycle.
- ovf  output  1  input exceeded 9999; held with bcd.
- bcd  output  16  {d3,d2,d1,d0}, d0 in [3:0]; connects to the display driver's x input.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, bcd=16'h0000, ovf=0, done=0, busy=0, shift register and counter cleared.
- FSM states and transitions:
  - IDLE -> SHIFT on start=1. The edge that accepts start loads shift register = {16'b0, bin}, sets cnt=0 and latches ovf_n = (bin > 9999).
  - SHIFT, each edge: every BCD nibble >= 5 gets +3 (combinational), then the whole {bcd_acc, bin_acc} register shifts left 1; cnt++.
  - The edge with cnt==BIN_W-1 performs the final shift, writes bcd<=result and ovf<=ovf_n, sets done<=1 and goes to DONE.
  - DONE -> IDLE unconditionally; done<=0.
- Latency: done is high in the cycle BIN_W clocks after the start-accept edge (14 cycles by default). Minimum start-to-start spacing is BIN_W+2 cycles.
- Input stability: bin is don't-care after the accept edge.
- start is ignored while busy; it is not queued.
- bcd and ovf are held between conversions, so the display stays stable.
- Accumulator width: 16 bits (4 digits). For inputs above 9999, the carry out of d3 is discarded, so the raw result is bin mod 10000.
- BIN_W <= 13 covers 0..8191; ovf is then never set.
- Reset mid-operation aborts the conversion: outputs return to reset values and no done pulse is produced.
- A start arriving on the same edge as clr deassertion is not accepted.

Optional Feature:
- Macro: BIN2BCD_SAT_EN.
- Defined: when ovf_n=1 the DONE write forces bcd=16'h9999 (saturation); ovf=1.
- Undefined: bcd = bin mod 10000 (wrapped); ovf=1.
- Latency, handshake and ovf behaviour are identical in both builds.

Decomposition:
- Package x7seg_pkg:
  - State enum {IDLE, SHIFT, DONE} in 2 bits.
  - BCD_W=4, NUM_DIGITS=4, MAX_DEC=14'd9999, SAT_VALUE=16'h9999.
  - Shared with the display driver for the digit width and digit count.
- Sub-module bcd_add3: combinational per-digit correction, 4-bit in -> 4-bit out, (d>=5)?d+3:d. Instantiated NUM_DIGITS times.

Test Plan:
- clr pulse, then idle -> bcd=16'h0000, ovf=0, busy=0, done=0. start with bin=0 -> done at +14 cycles, bcd=16'h0000.
- bin=1234 start -> busy rises the next cycle; done exactly one cycle, 14 cycles after the accept edge; bcd=16'h1234, ovf=0; bcd held for 20 idle cycles.
- bin=9999 -> bcd=16'h9999, ovf=0. bin=10000 -> ovf=1; bcd=16'h9999 with BIN2BCD_SAT_EN, 16'h0000 without. bin=16383 -> 16'h9999 / 16'h6383.
- start re-asserted every cycle with bin switching to 42 mid-conversion of 4321 -> first result 16'h4321. Next accepted start comes only after IDLE; exactly one done per accepted start; spacing >= 16 cycles.
- clr asserted at cycle 7 of a 5678 conversion (previous result 16'h0321) -> bcd=16'h0000 immediately, no done pulse. A fresh start of 77 after release -> 16'h0077.
- Sweep 0..9999 with a reference model, plus a back-to-back chain into the display driver -> a_to_g decodes each digit correctly.
